snax_tcdm_rr_arbiter: RTL and testbench
=======================================

// Module: snax_tcdm_rr_arbiter
// PURPOSE
// Shares one reqrsp TCDM port among NumReq accelerator streamer/HWPE adapters.
// Arbitration is round-robin with a hold-on-stall rule. An in-order ID queue
// tracks outstanding transactions and routes each TCDM response back to its issuer.
// Sits between the per-stream hwpe->reqrsp adapters and the cluster TCDM interconnect port.
// PARAMETERS
// NumReq         4   number of requesters (>=2)
// AddrWidth      48  TCDM address width
// DataWidth      64  TCDM data width; StrbWidth = DataWidth/8
// MaxOutstanding 8   max granted-but-unanswered transactions (power of 2)
// PORTS
// clk_i           in   1                  clock
// rst_i           in   1                  reset, synchronous, active-high
// req_valid_i     in   NumReq             per-requester request valid
// req_ready_o     out  NumReq             per-requester accept (one-hot or zero)
// req_addr_i      in   NumReq*AddrWidth   packed addresses, requester i at slice i
// req_write_i     in   NumReq             1=write, 0=read
// req_data_i      in   NumReq*DataWidth   write data
// req_strb_i      in   NumReq*StrbWidth   byte strobes
// rsp_valid_o     out  NumReq             one-hot response valid
// rsp_data_o      out  DataWidth          response data, shared by all requesters
// tcdm_q_valid_o  out  1                  TCDM request valid
// tcdm_q_ready_i  in   1                  TCDM request ready
// tcdm_q_addr_o / _write_o / _data_o / _strb_o  out  AddrWidth/1/DataWidth/StrbWidth  muxed payload
// tcdm_p_valid_i  in   1                  TCDM response valid (one per request, in order)
// tcdm_p_data_i   in   DataWidth          TCDM response data
// outstanding_o   out  $clog2(MaxOutstanding)+1  in-flight count
// err_o           out  1                  sticky: response seen with empty ID queue
// BEHAVIOUR
// - Reset (rst_i=1 at posedge): rr_ptr=0, lock=0, ID queue empty, outstanding_o=0, err_o=0.
//   All outputs low while the queue is empty and no requester is valid. A reset during
//   operation drops every in-flight ID; responses arriving afterwards set err_o and are not routed.
// - Issue is allowed iff outstanding_o < MaxOutstanding. A pop in the same cycle does not free a slot.
// - Winner selection is combinational, 0-cycle latency: the first valid requester scanning
//   rr_ptr, rr_ptr+1, ... modulo NumReq. tcdm_q_* carries the winner's payload.
//   tcdm_q_valid_o = any valid && issue allowed.
// - Handshake: req_ready_o[w] = tcdm_q_ready_i && tcdm_q_valid_o, for the winner w only.
//   On handshake: push w to the ID queue and set rr_ptr = (w+1) mod NumReq.
// - Hold: if tcdm_q_valid_o && !tcdm_q_ready_i, register lock=1 and locked_id=w. While lock=1,
//   w keeps the grant regardless of rr_ptr. Requesters must hold valid and payload stable
//   until ready (reqrsp rule). lock clears on handshake.
// - Response: on tcdm_p_valid_i with a non-empty queue, rsp_valid_o[head]=1 and
//   rsp_data_o=tcdm_p_data_i in the same cycle, and the head pops. Writes also return a
//   response and are routed identically. A response with an empty queue sets err_o, no pop.
// - Counter: push only +1, pop only -1, push and pop together unchanged. It never exceeds MaxOutstanding.
// - A push and a pop in the same cycle with a non-empty queue are both legal. A push and a
//   response in the same cycle with an empty queue count as error, then push.
// STRUCTURE
// - snax_tcdm_arb_pkg: id_t = logic [$clog2(NumReq)-1:0], tcdm_q_payload_t struct
//   {addr, write, data, strb}, and a function rr_pick(valid, ptr) -> {found, id}.
// - Sub-module: ID queue = existing fifo_v3 (dtype id_t, DEPTH MaxOutstanding). The
//   arbiter owns rr_ptr, lock and the counter and does not rely on the fifo's empty/full flags for gating.
// TESTING
// 1 Reset, then req0 read 0x100 alone, ready=1 -> q_addr=0x100, ready_o=0001 in the same cycle;
//   p_valid with 0xDEAD -> rsp_valid_o=0001, rsp_data_o=0xDEAD.
// 2 All 4 valid, ready=1 for 8 cycles -> grant order 0,1,2,3,0,1,2,3; responses one-hot in the same order.
// 3 req2 wins, ready=0 for 3 cycles while req3 asserts -> payload stays req2's; after ready, req3 granted next.
// 4 MaxOutstanding=8, no responses, 10 requests -> 8 accepted, q_valid=0 and outstanding_o=8;
//   one p_valid -> no issue in that cycle, issue resumes the following cycle.
// 5 Reset asserted with 3 outstanding -> outstanding_o=0 next cycle; a later p_valid -> err_o=1, rsp_valid_o=0.
// 6 Push and pop in the same cycle at count 5 -> count stays 5 and routing is correct for the popped head.

Source files
------------

// File: rtl/snax_tcdm_arb_pkg.sv
// Shared types and helpers for the TCDM round-robin arbiter.
package snax_tcdm_arb_pkg;

    localparam int unsigned NUM_REQ         = 4;
    localparam int unsigned ADDR_WIDTH      = 48;
    localparam int unsigned DATA_WIDTH      = 64;
    localparam int unsigned STRB_WIDTH      = DATA_WIDTH / 8;
    localparam int unsigned MAX_OUTSTANDING = 8;
    localparam int unsigned ID_WIDTH        = $clog2(NUM_REQ);
    localparam int unsigned CNT_WIDTH       = $clog2(MAX_OUTSTANDING) + 1;

    typedef logic [ID_WIDTH-1:0] id_t;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic                  write;
        logic [DATA_WIDTH-1:0] data;
        logic [STRB_WIDTH-1:0] strb;
    } tcdm_q_payload_t;

    typedef struct packed {
        logic found;
        id_t  id;
    } pick_t;

    // First valid requester found scanning ptr, ptr+1, ... modulo NUM_REQ.
    function automatic pick_t rr_pick(input logic [NUM_REQ-1:0] valid, input id_t ptr);
        pick_t res;
        id_t   idx;
        res = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx = id_t'((32'(ptr) + i) % NUM_REQ);
            if (!res.found && valid[idx]) begin
                res.found = 1'b1;
                res.id    = idx;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/fifo_v3.sv
// Small synchronous FIFO holding requester IDs in issue order.
// DEPTH must be a power of two; pointers wrap by overflow. The owner
// guarantees it never pushes when full nor pops when empty.
module fifo_v3 #(
    parameter int unsigned DEPTH = 8,
    parameter type         dtype = logic
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic push_i,
    input  dtype data_i,
    input  logic pop_i,
    output dtype data_o
);

    localparam int unsigned PtrWidth = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [PtrWidth-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrWidth-1:0] rd_ptr_q, rd_ptr_d;
    dtype                mem_q [DEPTH];

    // Advance write/read pointers on push/pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
    end

    // Pointer registers; reset empties the queue.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage write; contents need no reset since the pointers define validity.
    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[wr_ptr_q] <= data_i;
    end

    assign data_o = mem_q[rd_ptr_q];

endmodule

// File: rtl/snax_tcdm_rr_arbiter.sv
// Round-robin arbiter sharing one reqrsp TCDM port among NumReq requesters.
// A stalled winner keeps the grant until accepted; an in-order ID queue
// routes each TCDM response back to the requester that issued it.
module snax_tcdm_rr_arbiter
    import snax_tcdm_arb_pkg::*;
#(
    parameter int unsigned NumReq         = NUM_REQ,
    parameter int unsigned AddrWidth      = ADDR_WIDTH,
    parameter int unsigned DataWidth      = DATA_WIDTH,
    parameter int unsigned StrbWidth      = DataWidth / 8,
    parameter int unsigned MaxOutstanding = MAX_OUTSTANDING
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic [NumReq-1:0]                   req_valid_i,
    output logic [NumReq-1:0]                   req_ready_o,
    input  logic [NumReq*AddrWidth-1:0]         req_addr_i,
    input  logic [NumReq-1:0]                   req_write_i,
    input  logic [NumReq*DataWidth-1:0]         req_data_i,
    input  logic [NumReq*StrbWidth-1:0]         req_strb_i,
    output logic [NumReq-1:0]                   rsp_valid_o,
    output logic [DataWidth-1:0]                rsp_data_o,
    output logic                                tcdm_q_valid_o,
    input  logic                                tcdm_q_ready_i,
    output logic [AddrWidth-1:0]                tcdm_q_addr_o,
    output logic                                tcdm_q_write_o,
    output logic [DataWidth-1:0]                tcdm_q_data_o,
    output logic [StrbWidth-1:0]                tcdm_q_strb_o,
    input  logic                                tcdm_p_valid_i,
    input  logic [DataWidth-1:0]                tcdm_p_data_i,
    output logic [$clog2(MaxOutstanding):0]     outstanding_o,
    output logic                                err_o
);

    // Handshake: a request transfers in the cycle where tcdm_q_valid_o and
    // tcdm_q_ready_i are both high; req_ready_o mirrors that for the winner only.
    // Requesters keep valid and payload stable until they see req_ready_o.

    id_t                  rr_ptr_q, rr_ptr_d;
    logic                 lock_q, lock_d;
    id_t                  locked_id_q, locked_id_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 err_q, err_d;

    tcdm_q_payload_t payload [NumReq];
    pick_t           pick;
    id_t             winner;
    logic            any_sel;
    logic            issue_allowed;
    logic            q_valid;
    logic            handshake;
    logic            queue_nonempty;
    logic            pop;
    id_t             head_id;

    // Unpack the flat request buses into per-requester payload structs.
    always_comb begin
        for (int i = 0; i < NumReq; i++) begin
            payload[i].addr  = req_addr_i[i*AddrWidth +: AddrWidth];
            payload[i].write = req_write_i[i];
            payload[i].data  = req_data_i[i*DataWidth +: DataWidth];
            payload[i].strb  = req_strb_i[i*StrbWidth +: StrbWidth];
        end
    end

    // Winner: the locked requester while it stalls, otherwise round-robin pick.
    always_comb begin
        pick = rr_pick(req_valid_i, rr_ptr_q);
        if (lock_q && req_valid_i[locked_id_q]) begin
            winner  = locked_id_q;
            any_sel = 1'b1;
        end else begin
            winner  = pick.id;
            any_sel = pick.found;
        end
    end

    // Slot accounting uses the registered count, so a same-cycle pop frees nothing.
    assign issue_allowed  = cnt_q < CNT_WIDTH'(MaxOutstanding);
    assign q_valid        = any_sel && issue_allowed;
    assign handshake      = q_valid && tcdm_q_ready_i;
    assign queue_nonempty = cnt_q != '0;
    assign pop            = tcdm_p_valid_i && queue_nonempty;

    // Drive the TCDM request, requester accepts and routed response.
    always_comb begin
        tcdm_q_valid_o = q_valid;
        tcdm_q_addr_o  = '0;
        tcdm_q_write_o = 1'b0;
        tcdm_q_data_o  = '0;
        tcdm_q_strb_o  = '0;
        req_ready_o    = '0;
        rsp_valid_o    = '0;
        rsp_data_o     = '0;
        if (q_valid) begin
            tcdm_q_addr_o  = payload[winner].addr;
            tcdm_q_write_o = payload[winner].write;
            tcdm_q_data_o  = payload[winner].data;
            tcdm_q_strb_o  = payload[winner].strb;
        end
        if (handshake) req_ready_o[winner] = 1'b1;
        if (pop) begin
            rsp_valid_o[head_id] = 1'b1;
            rsp_data_o           = tcdm_p_data_i;
        end
    end

    // Next state for pointer, lock, in-flight count and sticky error.
    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        lock_d      = lock_q;
        locked_id_d = locked_id_q;
        cnt_d       = cnt_q;
        err_d       = err_q;
        if (handshake) begin
            rr_ptr_d = (winner == id_t'(NumReq - 1)) ? '0 : winner + 1'b1;
            lock_d   = 1'b0;
        end else if (q_valid) begin
            lock_d      = 1'b1;
            locked_id_d = winner;
        end else begin
            lock_d = 1'b0;
        end
        if (tcdm_p_valid_i && !queue_nonempty) err_d = 1'b1;
        case ({handshake, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_ptr_q    <= '0;
            lock_q      <= 1'b0;
            locked_id_q <= '0;
            cnt_q       <= '0;
            err_q       <= 1'b0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            lock_q      <= lock_d;
            locked_id_q <= locked_id_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
        end
    end

    fifo_v3 #(
        .DEPTH (MaxOutstanding),
        .dtype (id_t)
    ) i_id_fifo (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .push_i (handshake),
        .data_i (winner),
        .pop_i  (pop),
        .data_o (head_id)
    );

    assign outstanding_o = cnt_q;
    assign err_o         = err_q;

endmodule

// File: tb/tb_snax_tcdm_rr_arbiter.sv
// Self-checking bench for snax_tcdm_rr_arbiter: directed scenarios plus a
// random phase, all checked against a queue-based reference model.
module tb_snax_tcdm_rr_arbiter;

    localparam int N    = 4;
    localparam int AW   = 48;
    localparam int DW   = 64;
    localparam int SW   = 8;
    localparam int MAXO = 8;

    // ---------------- clock / reset / signals ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_write;
    logic [AW-1:0]   a_addr [N];
    logic [DW-1:0]   a_data [N];
    logic [SW-1:0]   a_strb [N];
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_data;
    logic [N*SW-1:0] req_strb;

    logic [N-1:0]    req_ready;
    logic [N-1:0]    rsp_valid;
    logic [DW-1:0]   rsp_data;
    logic            tcdm_q_valid;
    logic            tcdm_q_ready;
    logic [AW-1:0]   tcdm_q_addr;
    logic            tcdm_q_write;
    logic [DW-1:0]   tcdm_q_data;
    logic [SW-1:0]   tcdm_q_strb;
    logic            tcdm_p_valid;
    logic [DW-1:0]   tcdm_p_data;
    logic [3:0]      outstanding;
    logic            err;

    always_comb begin
        req_addr = '0;
        req_data = '0;
        req_strb = '0;
        for (int i = 0; i < N; i++) begin
            req_addr[i*AW +: AW] = a_addr[i];
            req_data[i*DW +: DW] = a_data[i];
            req_strb[i*SW +: SW] = a_strb[i];
        end
    end

    snax_tcdm_rr_arbiter dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .req_valid_i    (req_valid),
        .req_ready_o    (req_ready),
        .req_addr_i     (req_addr),
        .req_write_i    (req_write),
        .req_data_i     (req_data),
        .req_strb_i     (req_strb),
        .rsp_valid_o    (rsp_valid),
        .rsp_data_o     (rsp_data),
        .tcdm_q_valid_o (tcdm_q_valid),
        .tcdm_q_ready_i (tcdm_q_ready),
        .tcdm_q_addr_o  (tcdm_q_addr),
        .tcdm_q_write_o (tcdm_q_write),
        .tcdm_q_data_o  (tcdm_q_data),
        .tcdm_q_strb_o  (tcdm_q_strb),
        .tcdm_p_valid_i (tcdm_p_valid),
        .tcdm_p_data_i  (tcdm_p_data),
        .outstanding_o  (outstanding),
        .err_o          (err)
    );

    // ---------------- reference model state ----------------
    int m_q[$];        // requester IDs in flight, oldest first
    int m_ptr;         // requester scanned first
    bit m_lock;
    int m_lock_id;
    bit m_err;
    bit last_hs;
    int last_w;

    int n_vec = 0;
    int n_err = 0;

    function automatic logic [N-1:0] one_hot(input int i);
        logic [N-1:0] r;
        r    = '0;
        r[i] = 1'b1;
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Check every output against the model for the current inputs, advance
    // the model, then move to 1 time unit after the next rising edge.
    task automatic cycle();
        bit found;
        bit qv;
        bit hs;
        bit pop;
        int w;
        #2;
        found = 1'b0;
        w     = 0;
        if (m_lock && req_valid[m_lock_id]) begin
            found = 1'b1;
            w     = m_lock_id;
        end else begin
            for (int k = 0; k < N; k++) begin
                int c;
                c = (m_ptr + k) % N;
                if (!found && req_valid[c]) begin
                    found = 1'b1;
                    w     = c;
                end
            end
        end
        qv  = found && (m_q.size() < MAXO);
        hs  = qv && tcdm_q_ready;
        pop = tcdm_p_valid && (m_q.size() > 0);

        chk("q_valid",     tcdm_q_valid, qv);
        chk("q_addr",      tcdm_q_addr,  qv ? a_addr[w] : 48'h0);
        chk("q_write",     tcdm_q_write, qv ? req_write[w] : 1'b0);
        chk("q_data",      tcdm_q_data,  qv ? a_data[w] : 64'h0);
        chk("q_strb",      tcdm_q_strb,  qv ? a_strb[w] : 8'h0);
        chk("req_ready",   req_ready,    hs ? one_hot(w) : 4'h0);
        chk("rsp_valid",   rsp_valid,    pop ? one_hot(m_q[0]) : 4'h0);
        chk("rsp_data",    rsp_data,     pop ? tcdm_p_data : 64'h0);
        chk("outstanding", outstanding,  64'(m_q.size()));
        chk("err",         err,          m_err);

        last_hs = hs;
        last_w  = w;
        if (rst) begin
            m_q.delete();
            m_ptr  = 0;
            m_lock = 1'b0;
            m_err  = 1'b0;
        end else begin
            if (tcdm_p_valid) begin
                if (m_q.size() > 0) void'(m_q.pop_front());
                else m_err = 1'b1;
            end
            if (hs) begin
                m_q.push_back(w);
                m_ptr  = (w + 1) % N;
                m_lock = 1'b0;
            end else if (qv) begin
                m_lock    = 1'b1;
                m_lock_id = w;
            end else begin
                m_lock = 1'b0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    // ---------------- driver tasks ----------------
    task automatic set_req(input int i, input logic [AW-1:0] a, input bit wr);
        req_valid[i] = 1'b1;
        a_addr[i]    = a;
        req_write[i] = wr;
        a_data[i]    = {$urandom, $urandom};
        a_strb[i]    = 8'($urandom);
    endtask

    task automatic clr_all();
        req_valid = '0;
        req_write = '0;
        for (int i = 0; i < N; i++) begin
            a_addr[i] = '0;
            a_data[i] = '0;
            a_strb[i] = '0;
        end
    endtask

    task automatic do_reset();
        rst          = 1'b1;
        clr_all();
        tcdm_q_ready = 1'b0;
        tcdm_p_valid = 1'b0;
        tcdm_p_data  = '0;
        cycle();
        rst = 1'b0;
    endtask

    task automatic drain();
        req_valid    = '0;
        tcdm_q_ready = 1'b0;
        while (m_q.size() > 0) begin
            tcdm_p_valid = 1'b1;
            tcdm_p_data  = {$urandom, $urandom};
            cycle();
        end
        tcdm_p_valid = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        m_ptr = 0; m_lock = 1'b0; m_lock_id = 0; m_err = 1'b0;
        last_hs = 1'b0; last_w = 0;
        rst = 1'b1;
        clr_all();
        tcdm_q_ready = 1'b0;
        tcdm_p_valid = 1'b0;
        tcdm_p_data  = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        // reset state checked against the model (all outputs low)
        cycle();
        rst = 1'b0;

        // 1: single read from req0, then its response
        set_req(0, 48'h100, 1'b0);
        tcdm_q_ready = 1'b1;
        #1;
        chk("t1_addr",  tcdm_q_addr, 48'h100);
        chk("t1_ready", req_ready, 4'b0001);
        cycle();
        req_valid    = '0;
        tcdm_q_ready = 1'b0;
        tcdm_p_valid = 1'b1;
        tcdm_p_data  = 64'hDEAD;
        #1;
        chk("t1_rsp_valid", rsp_valid, 4'b0001);
        chk("t1_rsp_data",  rsp_data, 64'hDEAD);
        cycle();
        tcdm_p_valid = 1'b0;

        // 2: all four valid for 8 cycles -> strict rotation, responses in order
        do_reset();
        tcdm_q_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < N; i++) set_req(i, AW'($urandom), 1'($urandom));
            #1;
            chk("t2_grant", req_ready, one_hot(k % N));
            cycle();
        end
        req_valid    = '0;
        tcdm_q_ready = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tcdm_p_valid = 1'b1;
            tcdm_p_data  = {$urandom, $urandom};
            #1;
            chk("t2_rsp", rsp_valid, one_hot(k % N));
            cycle();
        end
        tcdm_p_valid = 1'b0;

        // 3: req2 stalls 3 cycles while req3 then req0 join; lock holds req2
        set_req(2, 48'h2222, 1'b1);
        tcdm_q_ready = 1'b0;
        cycle();
        set_req(3, 48'h3333, 1'b0);
        cycle();
        set_req(0, 48'h0000_0ABC, 1'b0);
        #1;
        chk("t3_hold_addr", tcdm_q_addr, 48'h2222);
        cycle();
        tcdm_q_ready = 1'b1;
        #1;
        chk("t3_grant2", req_ready, 4'b0100);
        cycle();
        req_valid[2] = 1'b0;
        #1;
        chk("t3_grant3", req_ready, 4'b1000);
        cycle();
        req_valid[3] = 1'b0;
        cycle();
        drain();

        // 4: saturate the outstanding limit, then one response
        do_reset();
        tcdm_q_ready = 1'b1;
        set_req(0, AW'($urandom), 1'b0);
        for (int k = 0; k < 10; k++) begin
            cycle();
            if (last_hs) set_req(0, AW'($urandom), 1'($urandom));
        end
        chk("t4_outstanding", outstanding, 64'd8);
        chk("t4_q_valid", tcdm_q_valid, 1'b0);
        tcdm_p_valid = 1'b1;
        tcdm_p_data  = {$urandom, $urandom};
        #1;
        chk("t4_no_issue_on_pop", tcdm_q_valid, 1'b0);
        cycle();
        tcdm_p_valid = 1'b0;
        #1;
        chk("t4_issue_resumes", tcdm_q_valid, 1'b1);
        cycle();
        drain();

        // 5: reset with 3 outstanding, then a stray response
        do_reset();
        tcdm_q_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            set_req(k, AW'($urandom), 1'b0);
            cycle();
            req_valid[k] = 1'b0;
        end
        do_reset();
        chk("t5_outstanding", outstanding, 64'd0);
        tcdm_p_valid = 1'b1;
        tcdm_p_data  = 64'hBEEF;
        cycle();
        tcdm_p_valid = 1'b0;
        chk("t5_err", err, 1'b1);
        cycle();

        // 6: push and pop together at count 5
        do_reset();
        tcdm_q_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            for (int i = 0; i < N; i++) set_req(i, AW'($urandom), 1'($urandom));
            cycle();
        end
        set_req(1, AW'($urandom), 1'b1);
        tcdm_p_valid = 1'b1;
        tcdm_p_data  = {$urandom, $urandom};
        #1;
        chk("t6_rsp_head", rsp_valid, 4'b0001);
        cycle();
        tcdm_p_valid = 1'b0;
        req_valid    = '0;
        chk("t6_outstanding", outstanding, 64'd5);
        cycle();
        drain();

        // random phase: requesters obey hold-until-ready
        do_reset();
        for (int k = 0; k < 400; k++) begin
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] && ($urandom_range(0, 1) == 1))
                    set_req(i, AW'({$urandom, $urandom}), 1'($urandom));
            end
            tcdm_q_ready = ($urandom_range(0, 3) != 0);
            tcdm_p_valid = (m_q.size() > 0) && ($urandom_range(0, 2) != 0);
            tcdm_p_data  = {$urandom, $urandom};
            cycle();
            if (last_hs) req_valid[last_w] = 1'b0;
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
